score_disp_driver: RTL and testbench

//   Converts a binary score to four BCD digits with a sequential shift-add-3 (double-dabble) engine.

---
 rtl/score_disp_pkg.sv | 30 +++
 rtl/score_disp_driver_bin_to_bcd_seq.sv | 97 +++++++++
 rtl/score_disp_driver.sv | 147 ++++++++++++++
 tb/tb_score_disp_driver.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_disp_pkg.sv
// Shared definitions for the score display driver: digit count, blank code,
// anode reset pattern, conversion FSM states and the double-dabble adjust step.
package score_disp_pkg;

    localparam int         NDIG       = 4;
    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [3:0] AN_RESET   = 4'b1110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    // Add 3 to every BCD nibble that is 5 or more. This prepares the
    // nibbles for the following left shift.
    function automatic logic [4*NDIG-1:0] dd_adjust(input logic [4*NDIG-1:0] bcd);
        logic [4*NDIG-1:0] res;
        res = bcd;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end else begin
                res[i*4 +: 4] = bcd[i*4 +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/score_disp_driver_bin_to_bcd_seq.sv
// Iterative double-dabble converter. One conversion takes BIN_W iteration
// cycles followed by a single COMMIT cycle, during which done is high and
// bcd holds the final result.
module bin_to_bcd_seq
    import score_disp_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BIN_W-1:0]  bin,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] bcd
);

    localparam int CW = $clog2(BIN_W + 1);

    conv_state_t       state_r;
    conv_state_t       state_nxt_s;
    logic [CW-1:0]     cnt_r;
    logic [BIN_W-1:0]  bin_sh_r;
    logic [4*NDIG-1:0] bcd_r;
    logic [4*NDIG-1:0] adj_s;
    logic              busy_r;
    logic              done_r;

    // Next-state logic and the adjusted scratch value for the current iteration.
    always_comb begin
        state_nxt_s = state_r;
        adj_s       = dd_adjust(bcd_r);
        case (state_r)
            IDLE: begin
                if (load) begin
                    state_nxt_s = CONV;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CONV: begin
                if (cnt_r == CW'(BIN_W - 1)) begin
                    state_nxt_s = COMMIT;
                end else begin
                    state_nxt_s = CONV;
                end
            end
            COMMIT:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Register the state, with busy and done derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
            done_r  <= (state_nxt_s == COMMIT);
        end
    end

    // Datapath: capture the operand on load, then adjust and shift once per CONV cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= '0;
            bin_sh_r <= '0;
            bcd_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (load) begin
                        cnt_r    <= '0;
                        bin_sh_r <= bin;
                        bcd_r    <= '0;
                    end
                end
                CONV: begin
                    cnt_r    <= cnt_r + CW'(1);
                    bcd_r    <= {adj_s[4*NDIG-2:0], bin_sh_r[BIN_W-1]};
                    bin_sh_r <= {bin_sh_r[BIN_W-2:0], 1'b0};
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign bcd  = bcd_r;

endmodule

// File: rtl/score_disp_driver.sv
// Score display driver: saturates the binary score, converts it to BCD,
// commits the digits atomically and time-multiplexes them onto a 4-digit
// common-anode display.
// Optional build macro LEADING_ZERO_BLANK_EN: leading zero digits above the
// ones digit are replaced with BLANK_CODE.
module score_disp_driver
    import score_disp_pkg::*;
#(
    parameter int BIN_W    = 14,
    parameter int MAX_VAL  = 9999,
    parameter int SCAN_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic             sat,
    output logic [3:0]       digit,
    output logic [3:0]       an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic              over_s;
    logic [BIN_W-1:0]  clip_s;
    logic              accept_s;
    logic [4*NDIG-1:0] bcd_s;
    logic [NDIG-1:0]   lzb_s;
    logic [4*NDIG-1:0] digits_r;
    logic [4*NDIG-1:0] digits_nxt_s;
    logic [NDIG-1:0]   blank_r;
    logic [NDIG-1:0]   blank_nxt_s;
    logic [PW-1:0]     pre_r;
    logic              tick_s;
    logic [1:0]        idx_r;
    logic [1:0]        idx_nxt_s;
    logic [3:0]        code_nxt_s;
    logic              sat_r;
    logic [3:0]        an_r;
    logic [3:0]        digit_r;

    bin_to_bcd_seq #(.BIN_W(BIN_W)) u_conv (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .bin  (clip_s),
        .busy (busy),
        .done (done),
        .bcd  (bcd_s)
    );

    // Saturate the operand and flag an accepted load.
    always_comb begin
        over_s   = (bin_in > BIN_W'(MAX_VAL));
        clip_s   = bin_in;
        accept_s = load & ~busy;
        if (over_s) begin
            clip_s = BIN_W'(MAX_VAL);
        end else begin
            clip_s = bin_in;
        end
    end

    // Leading-zero blank flags for the converter result; bit 0 (ones) is never blanked.
    always_comb begin
        lzb_s = '0;
`ifdef LEADING_ZERO_BLANK_EN
        lzb_s[3] = (bcd_s[15:12] == 4'd0);
        lzb_s[2] = lzb_s[3] && (bcd_s[11:8] == 4'd0);
        lzb_s[1] = lzb_s[2] && (bcd_s[7:4] == 4'd0);
        lzb_s[0] = 1'b0;
`else
        lzb_s = 4'b0000;
`endif
    end

    // Next committed digits, next scan slot and the code that slot will show.
    always_comb begin
        digits_nxt_s = digits_r;
        blank_nxt_s  = blank_r;
        idx_nxt_s    = idx_r;
        tick_s       = (pre_r == PW'(SCAN_DIV - 1));
        if (done) begin
            digits_nxt_s = bcd_s;
            blank_nxt_s  = lzb_s;
        end else begin
            digits_nxt_s = digits_r;
            blank_nxt_s  = blank_r;
        end
        if (tick_s) begin
            idx_nxt_s = idx_r + 2'd1;
        end else begin
            idx_nxt_s = idx_r;
        end
        if (blank_nxt_s[idx_nxt_s]) begin
            code_nxt_s = BLANK_CODE;
        end else begin
            code_nxt_s = digits_nxt_s[{idx_nxt_s, 2'b00} +: 4];
        end
    end

    // Saturation flag follows each accepted load and holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_r <= 1'b0;
        end else if (accept_s) begin
            sat_r <= over_s;
        end
    end

    // Committed digits change only when the converter reports COMMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_r <= '0;
            blank_r  <= '0;
        end else begin
            digits_r <= digits_nxt_s;
            blank_r  <= blank_nxt_s;
        end
    end

    // Free-running scan prescaler and slot index, with registered anode and digit outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_r   <= '0;
            idx_r   <= 2'd0;
            an_r    <= AN_RESET;
            digit_r <= 4'h0;
        end else begin
            if (tick_s) begin
                pre_r <= '0;
            end else begin
                pre_r <= pre_r + PW'(1);
            end
            idx_r   <= idx_nxt_s;
            an_r    <= ~(4'b0001 << idx_nxt_s);
            digit_r <= code_nxt_s;
        end
    end

    assign sat   = sat_r;
    assign an    = an_r;
    assign digit = digit_r;

endmodule

// File: tb/tb_score_disp_driver.sv
// Self-checking bench for score_disp_driver with a fast scan (SCAN_DIV=4).
// Expected digits come from decimal arithmetic on the loaded value.
module tb_score_disp_driver;

    localparam int BIN_W    = 14;
    localparam int MAX_VAL  = 9999;
    localparam int SCAN_DIV = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load = 1'b0;
    logic [BIN_W-1:0] bin_in = '0;
    logic             busy;
    logic             done;
    logic             sat;
    logic [3:0]       digit;
    logic [3:0]       an;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    score_disp_driver #(.BIN_W(BIN_W), .MAX_VAL(MAX_VAL), .SCAN_DIV(SCAN_DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .bin_in (bin_in),
        .load   (load),
        .busy   (busy),
        .done   (done),
        .sat    (sat),
        .digit  (digit),
        .an     (an)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the scan slot is (cyc / SCAN_DIV) mod 4.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Displayed code for one slot of a value (0=ones .. 3=thousands).
    function automatic logic [3:0] exp_code(input int val, input int slot);
        int p;
        p = 1;
        for (int i = 0; i < slot; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && val < p) return 4'hF;
`endif
        return 4'((val / p) % 10);
    endfunction

    function automatic logic [15:0] exp_frame(input int val);
        logic [15:0] f;
        for (int s = 0; s < 4; s++) f[s*4 +: 4] = exp_code(val, s);
        return f;
    endfunction

    // Drive a load for one cycle starting at the current negedge.
    task automatic issue_load(input int v);
        bin_in = BIN_W'(v);
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        bin_in = BIN_W'($urandom);
    endtask

    // Sample from the negedge after the load edge until busy drops (bounded).
    task automatic wait_conv(output int busy_end, output int done_cnt, output int done_at);
        busy_end = -1;
        done_cnt = 0;
        done_at  = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                done_cnt++;
                done_at = k;
            end
            if (!busy) begin
                busy_end = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Record the digit shown in each anode slot over one full frame.
    task automatic observe_frame(output logic [15:0] seen, output int bad_an);
        seen   = 16'h0000;
        bad_an = 0;
        for (int k = 0; k < 4 * SCAN_DIV; k++) begin
            @(negedge clk);
            case (an)
                4'b1110: seen[3:0]   = digit;
                4'b1101: seen[7:4]   = digit;
                4'b1011: seen[11:8]  = digit;
                4'b0111: seen[15:12] = digit;
                default: bad_an++;
            endcase
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({an, digit, busy, done, sat} !== {4'b1110, 4'h0, 3'b000}) begin
            errors++;
            $display("FAIL reset_state an=%b digit=%h busy=%b done=%b sat=%b required an=1110 digit=0 busy=0 done=0 sat=0",
                     an, digit, busy, done, sat);
        end
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp_an = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
            checks++;
            if (an !== exp_an || digit !== 4'h0) begin
                errors++;
                $display("FAIL reset_walk cyc=%0d an=%b digit=%h required an=%b digit=0", cyc, an, digit, exp_an);
            end
        end
    endtask

    // Full conversion with timing, sat and frame checks.
    task automatic run_value(input string name, input int v);
        int be, dc, da, bad;
        logic [15:0] seen, expf;
        int shown;
        shown = (v > MAX_VAL) ? MAX_VAL : v;
        issue_load(v);
        wait_conv(be, dc, da);
        checks++;
        if (be != BIN_W + 1 || dc != 1 || da != BIN_W) begin
            errors++;
            $display("FAIL %s_timing v=%0d busy_end=%0d done_cnt=%0d done_at=%0d required %0d 1 %0d",
                     name, v, be, dc, da, BIN_W + 1, BIN_W);
        end
        checks++;
        if (sat !== (v > MAX_VAL)) begin
            errors++;
            $display("FAIL %s_sat v=%0d sat=%b required %b", name, v, sat, (v > MAX_VAL));
        end
        observe_frame(seen, bad);
        expf = exp_frame(shown);
        checks++;
        if (seen !== expf || bad != 0) begin
            errors++;
            $display("FAIL %s_digits v=%0d seen=%h bad_an=%0d required %h bad_an=0", name, v, seen, bad, expf);
        end
    endtask

    task automatic test_load_1234();
        run_value("load1234", 1234);
    endtask

    task automatic test_saturation();
        run_value("sat12000", 12000);
        run_value("after_sat42", 42);
    endtask

    task automatic test_busy_ignore();
        int busy_cnt, done_cnt, bad;
        logic [15:0] seen, expf;
        busy_cnt = 0;
        done_cnt = 0;
        issue_load(5);
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (k == 2) begin
                load   = 1'b1;
                bin_in = BIN_W'(77);
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (busy_cnt != BIN_W + 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL busy_ignore busy_cycles=%0d done_cnt=%0d required %0d 1", busy_cnt, done_cnt, BIN_W + 1);
        end
        observe_frame(seen, bad);
        expf = exp_frame(5);
        checks++;
        if (seen !== expf || bad != 0) begin
            errors++;
            $display("FAIL busy_ignore_digits seen=%h bad_an=%0d required %h", seen, bad, expf);
        end
    endtask

    task automatic test_zero();
        run_value("zero", 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_value("random", int'($urandom_range(16383, 0)));
        end
    endtask

    task automatic test_back_to_back();
        int be, dc, da, bad;
        logic [15:0] seen, expf;
        int v1, v2;
        v1 = int'($urandom_range(9999, 1000));
        v2 = int'($urandom_range(999, 1));
        issue_load(v1);
        wait_conv(be, dc, da);
        issue_load(v2);
        wait_conv(be, dc, da);
        checks++;
        if (be != BIN_W + 1 || dc != 1 || da != BIN_W) begin
            errors++;
            $display("FAIL back_to_back_timing busy_end=%0d done_cnt=%0d done_at=%0d required %0d 1 %0d",
                     be, dc, da, BIN_W + 1, BIN_W);
        end
        observe_frame(seen, bad);
        expf = exp_frame(v2);
        checks++;
        if (seen !== expf || bad != 0) begin
            errors++;
            $display("FAIL back_to_back_digits v2=%0d seen=%h required %h", v2, seen, expf);
        end
    endtask

    task automatic test_reset_abort();
        int dc, bad;
        logic [15:0] seen;
        run_value("pre_abort", 8765);
        dc = 0;
        issue_load(9999);
        repeat (5) begin
            if (done) dc++;
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || an !== 4'b1110 || digit !== 4'h0) begin
            errors++;
            $display("FAIL abort_now busy=%b done=%b an=%b digit=%h required 0 0 1110 0", busy, done, an, digit);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) dc++;
            @(negedge clk);
        end
        checks++;
        if (dc != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done done_cnt=%0d busy=%b required 0 0", dc, busy);
        end
        observe_frame(seen, bad);
        checks++;
        if (seen !== 16'h0000 || bad != 0) begin
            errors++;
            $display("FAIL abort_digits seen=%h bad_an=%0d required 0000", seen, bad);
        end
    endtask

    initial begin
        test_reset();
        test_load_1234();
        test_saturation();
        test_busy_ignore();
        test_zero();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
